// File: rtl/demux_1_to_8_buf_pkg.sv
// Shared constants and helpers for the registered 1-to-8 word demultiplexer.
package demux_1_to_8_buf_pkg;

    localparam int SLOT_COUNT         = 8;
    localparam int SEL_WIDTH          = 3;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // How an accepted word is distributed across the output slots.
    typedef enum logic {
        MODE_UNICAST = 1'b0,
        MODE_BCAST   = 1'b1
    } mode_e;

    // One-hot slot mask for a unicast destination index.
    function automatic logic [SLOT_COUNT-1:0] slot_onehot(input logic [SEL_WIDTH-1:0] sel);
        logic [SLOT_COUNT-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: full flag plus data register, loaded by the
// distributor and drained by its own downstream consumer.
module demux_slot
    import demux_1_to_8_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  can_acc
);

    // The slot takes a new word when empty or when its current word leaves this cycle.
    assign can_acc = !valid || ready;

    // Full flag and data register: load wins over drain so a same-edge refill stays valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data register is reset as well, so downstream sees zeros rather than stale words after reset.
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments keep every register update on this edge based on pre-edge values.
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_to_8_buf.sv
// Registered 1-to-8 demultiplexer: steers an accepted word into one of eight
// one-entry slots (or all of them on broadcast); each slot drains independently.
module demux_1_to_8_buf
    import demux_1_to_8_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SEL_WIDTH-1:0]             in_sel,
    input  logic                             in_bcast,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic [SLOT_COUNT-1:0]            out_valid,
    input  logic [SLOT_COUNT-1:0]            out_ready,
    output logic [SLOT_COUNT*DATA_WIDTH-1:0] out_data
);

    logic [SLOT_COUNT-1:0] can_acc;
    logic [SLOT_COUNT-1:0] target;
    logic [SLOT_COUNT-1:0] load;
    mode_e                 mode;

    assign mode = mode_e'(in_bcast);

    // Select decode and readiness: broadcast is all-or-nothing, so it needs every slot free.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        target   = '0;
        in_ready = 1'b0;
        case (mode)
            MODE_BCAST: begin
                target   = '1;
                in_ready = &can_acc;
            end
            default: begin
                target   = slot_onehot(in_sel);
                in_ready = can_acc[in_sel];
            end
        endcase
        load = target & {SLOT_COUNT{in_valid && in_ready}};
    end

    for (genvar i = 0; i < SLOT_COUNT; i++) begin : g_slot
        demux_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[i]),
            .load_data (in_data),
            .ready     (out_ready[i]),
            .valid     (out_valid[i]),
            .data      (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .can_acc   (can_acc[i])
        );
    end

endmodule

// File: tb/tb_demux_1_to_8_buf.sv
// Scoreboard bench for demux_1_to_8_buf: directed scenarios plus random traffic,
// checked against per-slot queues of words owed to each consumer.
module tb_demux_1_to_8_buf;

    localparam int DW = 32;
    localparam int NS = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sel;
    logic             in_bcast;
    logic [DW-1:0]    in_data;
    logic [NS-1:0]    out_valid;
    logic [NS-1:0]    out_ready;
    logic [NS*DW-1:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words still owed to each slot's consumer, oldest first.
    logic [DW-1:0] exp_q [NS][$];

    demux_1_to_8_buf #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        return out_data[i*DW +: DW];
    endfunction

    // Monitor: at each falling edge compare DUT outputs to the model, then
    // retire drained words and enqueue the word accepted on the coming edge.
    always @(negedge clk) begin : monitor
        logic [NS-1:0] exp_valid;
        logic [NS-1:0] free;
        logic          exp_ready;
        if (reset) begin
            for (int i = 0; i < NS; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < NS; i++) begin
                exp_valid[i] = (exp_q[i].size() != 0);
                free[i]      = (exp_q[i].size() == 0) || out_ready[i];
            end
            check("mon_out_valid", out_valid, exp_valid);
            for (int i = 0; i < NS; i++)
                if (exp_valid[i]) check($sformatf("mon_slot%0d_data", i), slot(i), exp_q[i][0]);
            exp_ready = 1'b1;
            if (in_bcast) begin
                for (int i = 0; i < NS; i++) exp_ready = exp_ready && free[i];
            end else begin
                exp_ready = free[in_sel];
            end
            check("mon_in_ready", in_ready, exp_ready);
            for (int i = 0; i < NS; i++)
                if (exp_q[i].size() != 0 && out_ready[i]) void'(exp_q[i].pop_front());
            if (in_valid && exp_ready)
                for (int i = 0; i < NS; i++)
                    if (in_bcast || in_sel == 3'(i)) exp_q[i].push_back(in_data);
        end
    end

    // Present one word and hold it until accepted; starts and ends just after a rising edge.
    task automatic send(input logic [2:0] sel, input logic bcast, input logic [DW-1:0] data);
        bit acc = 0;
        in_sel   = sel;
        in_bcast = bcast;
        in_data  = data;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    // Empty every slot with one cycle of all-ready, then stall all consumers again.
    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = '1;
        @(posedge clk);
        #1;
        out_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int stalls;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_bcast  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_out_valid", out_valid, 8'h00);
        check("reset_in_ready", in_ready, 1);

        // Unicast sweep with every consumer stalled.
        for (int i = 0; i < NS; i++) send(3'(i), 1'b0, 32'hA000_0000 + 32'(i));
        check("sweep_out_valid", out_valid, 8'hFF);
        for (int i = 0; i < NS; i++) check($sformatf("sweep_slot%0d", i), slot(i), 32'hA000_0000 + 32'(i));
        in_sel = 3'($urandom_range(0, 7));
        in_bcast = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("sweep_full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Asynchronous reset with slots 2 and 5 full and a word on the input.
        drain_all();
        send(3'd2, 1'b0, 32'h2222_2222);
        send(3'd5, 1'b0, 32'h5555_5555);
        check("prereset_out_valid", out_valid, 8'h24);
        in_sel = 3'd0;
        in_data = 32'h0BAD_0BAD;
        in_valid = 1'b1;
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 8'h00);
        check("async_reset_data_nonzero", |out_data, 0);
        check("async_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Stall isolation: full slot 3 blocks only unicast to slot 3.
        send(3'd3, 1'b0, 32'h3333_3333);
        in_sel = 3'd3;
        in_data = 32'h1234_5678;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_sel3_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        check("stall_slot3_held", slot(3), 32'h3333_3333);
        in_sel = 3'd4;
        @(negedge clk);
        check("stall_sel4_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stall_slot4_data", slot(4), 32'h1234_5678);
        check("stall_out_valid", out_valid, 8'h18);

        // Same-cycle drain and load on slot 1.
        drain_all();
        send(3'd1, 1'b0, 32'h11);
        out_ready[1] = 1'b1;
        in_sel = 3'd1;
        in_data = 32'h22;
        in_valid = 1'b1;
        @(negedge clk);
        check("dl_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready[1] = 1'b0;
        check("dl_out_valid1", out_valid[1], 1);
        check("dl_slot1_data", slot(1), 32'h22);

        // Broadcast blocked by full slot 6, then released.
        drain_all();
        send(3'd6, 1'b0, 32'h66);
        in_bcast = 1'b1;
        in_sel = 3'($urandom_range(0, 7));
        in_data = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        @(negedge clk);
        check("bcast_blocked_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("bcast_blocked_out_valid", out_valid, 8'h40);
        check("bcast_blocked_slot6", slot(6), 32'h66);
        out_ready[6] = 1'b1;
        @(negedge clk);
        check("bcast_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bcast = 1'b0;
        out_ready[6] = 1'b0;
        check("bcast_out_valid", out_valid, 8'hFF);
        for (int i = 0; i < NS; i++) check($sformatf("bcast_slot%0d", i), slot(i), 32'hDEAD_BEEF);

        // Streaming: 100 random unicast words at full rate, all consumers ready.
        drain_all();
        out_ready = '1;
        stalls = 0;
        for (int n = 0; n < 100; n++) begin
            in_sel = 3'($urandom_range(0, 7));
            in_bcast = 1'b0;
            in_data = $urandom;
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stream_stalls", 64'(stalls), 0);

        // Random traffic: random valid, select, broadcast and consumer readiness.
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bcast = ($urandom_range(0, 7) == 0);
            in_sel = 3'($urandom_range(0, 7));
            in_data = $urandom;
            out_ready = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        check("final_out_valid", out_valid, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
